if_fetch_unit: RTL
==================

Name: if_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the ID stage and its register file.
- Owns the PC and issues in-order word requests to instruction memory over a valid/ready request channel plus a fixed-order response channel.
- Buffers returned instructions with their PCs in a small FIFO and hands them to decode over a valid/ready interface.
- Accepts redirects from branch/jump resolution, flushing buffered and in-flight fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- FIFO_DEPTH, 4, instruction buffer entries and max in-flight requests; power of 2, at least 2.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  word-aligned fetch address
- imem_rsp_valid  input  1  response valid; responses return in request order
- imem_rsp_data  input  32  fetched instruction
- redirect_valid  input  1  branch/jump taken, one-cycle pulse
- redirect_pc  input  32  new fetch target
- id_valid  output  1  instruction available to ID
- id_ready  input  1  ID consumes instruction
- id_instr  output  32  instruction to ID
- id_pc  output  32  PC of id_instr

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
- Reset values: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, imem_req_valid=0, id_valid=0, id_pc=0, id_instr=32'h0000_0013 (NOP).
- While id_valid=0, id_instr is forced to NOP and id_pc to 0.
- Request issue: imem_req_valid=1 when (outstanding + fifo_count) < FIFO_DEPTH.
- imem_req_addr=fetch_pc, and fetch_pc bits [1:0] are always 0.
- On a request handshake (valid & ready): fetch_pc += 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 0), and outstanding += 1.
- imem_req_valid and imem_req_addr hold stable until ready; exception: a redirect changes them.
- First request is presented the cycle after rst deasserts.
- Response: each imem_rsp_valid decrements outstanding.
  - If discard>0: discard -= 1, data dropped.
  - Else: {rsp_pc, data} is pushed to the FIFO. rsp_pc is tracked by a separate response-PC register that advances by 4 per accepted response.
- Capacity: a response push never overflows; the credit rule guarantees a free entry. The bench asserts this.
- Latency: response at cycle M -> id_valid=1 at M+1 when the FIFO was empty.
- ID handshake: id_valid & id_ready pops the head. Push and pop in the same cycle leave the count unchanged.
- FIFO full: requests stall (imem_req_valid=0) but already-issued responses are still accepted.
- Redirect (cycle N), highest priority:
  - FIFO is cleared; id_valid=0 from N+1.
  - fetch_pc and response-PC are set to {redirect_pc[31:2],2'b00}.
  - discard is set to outstanding, including a request handshaking in cycle N, minus any response arriving in cycle N; that response is itself dropped.
  - imem_req_valid may be 1 with the new address at N+1.
- Redirect while a request is pending but not yet accepted: the address switches at N+1; no stale request is counted.
- Redirect and ID handshake in the same cycle: the pop is ignored; the FIFO is cleared anyway.
- Back-to-back redirects: the last one wins. discard accumulates correctly because the counter is recomputed every cycle.
- Counter widths: outstanding, discard and count are $clog2(FIFO_DEPTH)+1 bits.
- Reset mid-operation: all state returns to reset values immediately. Responses for pre-reset requests are the memory's responsibility; the memory is reset with the same rst.

Optional Feature:
- Macro: IF_BYPASS_EN.
- Defined: when the FIFO is empty, discard=0, no redirect this cycle and imem_rsp_valid=1, the response drives id_valid/id_instr/id_pc combinationally in the same cycle.
  - If id_ready=1, the response is consumed without a push; otherwise it is pushed.
  - Latency is 0 cycles.
- Undefined: all responses pass through FIFO registers; latency is 1 cycle.

Test Plan:
- Reset then always-ready memory (1-cycle response) and id_ready=1 -> requests at 0x0,0x4,0x8...; ID sees (pc=0x0), (pc=0x4) in order; id_instr=imem data. Latency is 1 cycle without IF_BYPASS_EN, 0 with it.
- id_ready=0 and memory always ready -> exactly 4 requests issued (0x0..0xC), then imem_req_valid=0. FIFO holds 4; raising id_ready drains 4 and fetching resumes at 0x10.
- Memory latency 3 cycles, 3 in flight, redirect_pc=0x0000_0102 -> next request addr 0x100. The 3 stale responses are dropped; the first ID instruction has pc=0x100.
- Redirect in the same cycle as a response and as an ID pop -> response dropped, id_valid=0 next cycle, count=0.
- RESET_PC=32'hFFFF_FFF8 -> requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0; id_pc wraps identically.
- Assert rst mid-stream with 2 FIFO entries -> id_valid=0, id_instr=0x0000_0013 and imem_req_valid=0 during rst; first post-reset request addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order word fetches under a credit limit,
// and buffers returned instructions for decode. Optional same-cycle bypass under IF_BYPASS_EN.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int          PW  = $clog2(FIFO_DEPTH);
   localparam int          CW  = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outstanding_q, outstanding_d;
   logic [CW-1:0] discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic          active_q;

   logic [31:0]   fifo_instr_q [FIFO_DEPTH];
   logic [31:0]   fifo_pc_q    [FIFO_DEPTH];

   logic          req_hs;
   logic          bypass_w;
   logic          push_w;
   logic          pop_w;
   logic          rsp_keep;
   logic [CW:0]   credit_sum;
   logic [31:0]   redirect_aligned;
   logic          unused_redirect_bits;

   assign redirect_aligned     = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_bits = ^redirect_pc[1:0];

   // Every request in flight already owns a buffer slot, so a response can never overflow.
   assign credit_sum     = {1'b0, outstanding_q} + {1'b0, count_q};
   assign imem_req_valid = active_q && (credit_sum < (CW+1)'(FIFO_DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign req_hs         = imem_req_valid && imem_req_ready;

`ifdef IF_BYPASS_EN
   assign bypass_w = active_q && imem_rsp_valid && (count_q == '0) &&
                     (discard_q == '0) && !redirect_valid;
`else
   assign bypass_w = 1'b0;
`endif

   assign rsp_keep = imem_rsp_valid && (discard_q == '0) && !redirect_valid;
   assign push_w   = rsp_keep && !(bypass_w && id_ready);
   assign pop_w    = (count_q != '0) && id_ready && !redirect_valid;

   always_comb begin
      id_valid = 1'b0;
      id_instr = NOP;
      id_pc    = 32'h0;
      if (count_q != '0) begin
         id_valid = 1'b1;
         id_instr = fifo_instr_q[rd_ptr_q];
         id_pc    = fifo_pc_q[rd_ptr_q];
      end else if (bypass_w) begin
         id_valid = 1'b1;
         id_instr = imem_rsp_data;
         id_pc    = rsp_pc_q;
      end
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      rsp_pc_d      = rsp_pc_q;
      discard_d     = discard_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      outstanding_d = outstanding_q + CW'(req_hs) - CW'(imem_rsp_valid);

      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the old path.
         fetch_pc_d = redirect_aligned;
         rsp_pc_d   = redirect_aligned;
         discard_d  = outstanding_d;
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (req_hs) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
         end
         if (imem_rsp_valid) begin
            if (discard_q != '0) begin
               discard_d = discard_q - CW'(1);
            end else begin
               rsp_pc_d = rsp_pc_q + 32'd4;
            end
         end
         if (push_w) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         if (pop_w) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_w) - CW'(pop_w);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
         rsp_pc_q      <= {RESET_PC[31:2], 2'b00};
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         active_q      <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         rsp_pc_q      <= rsp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         active_q      <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_w) begin
         fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
         fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
      end
   end

endmodule
